// File: rtl/radiant_trig_scaler_if.sv
// Scaler I/O bundle: per-channel count pulses, gate controls and the registered readout port.
// master drives pulses, controls and address; slave (the scaler) returns data and latch status.
interface radiant_trig_scaler_if #(
    parameter int NCHAN      = 24,
    parameter int COUNT_BITS = 16
);
    logic [NCHAN-1:0]      scal_i;
    logic                  pps_en_i;
    logic                  pps_i;
    logic                  force_i;
    logic [4:0]            addr_i;
    logic [COUNT_BITS-1:0] dat_o;
    logic                  update_o;
    logic [15:0]           update_count_o;

    modport master (
        output scal_i, pps_en_i, pps_i, force_i, addr_i,
        input  dat_o, update_o, update_count_o
    );

    modport slave (
        input  scal_i, pps_en_i, pps_i, force_i, addr_i,
        output dat_o, update_o, update_count_o
    );
endinterface

// File: rtl/radiant_trig_scaler.sv
// Per-channel saturating trigger-rate scaler; totals latch on gate end, update_o one cycle later.
// Readout is a 1-cycle registered address/data port; no backpressure, every pulse cycle counts.
module radiant_trig_scaler #(
    parameter int NCHAN       = 24,
    parameter int COUNT_BITS  = 16,
    parameter int GATE_CYCLES = 50000000,
    parameter int GATE_BITS   = $clog2(GATE_CYCLES)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    radiant_trig_scaler_if.slave   bus
);

    localparam int                    GB        = (GATE_BITS < 1) ? 1 : GATE_BITS;
    localparam logic [GB-1:0]         GATE_LAST = GB'(GATE_CYCLES - 1);
    localparam logic [COUNT_BITS-1:0] CNT_MAX   = '1;
    localparam logic [4:0]            UCNT_ADDR = 5'(NCHAN);

    logic [COUNT_BITS-1:0] count_q [NCHAN];
    logic [COUNT_BITS-1:0] count_d [NCHAN];
    logic [COUNT_BITS-1:0] hold_q  [NCHAN];
    logic [COUNT_BITS-1:0] hold_d  [NCHAN];
    logic [COUNT_BITS-1:0] sum     [NCHAN];
    logic [GB-1:0]         gate_q, gate_d;
    logic                  pps_dly_q;
    logic                  end_evt;
    logic [COUNT_BITS-1:0] dat_q, dat_d;
    logic                  update_q;
    logic [15:0]           ucnt_q, ucnt_d;

    always_comb begin
        // All end sources collapse into one event, so coincident sources latch once.
        end_evt = (!bus.pps_en_i && (gate_q == GATE_LAST))
                | (bus.pps_en_i && bus.pps_i && !pps_dly_q)
                | bus.force_i;

        gate_d = (end_evt || (gate_q == GATE_LAST)) ? '0 : gate_q + 1'b1;

        for (int i = 0; i < NCHAN; i++) begin
            sum[i]     = (count_q[i] == CNT_MAX) ? CNT_MAX
                                                 : count_q[i] + COUNT_BITS'(bus.scal_i[i]);
            count_d[i] = end_evt ? '0 : sum[i];
            hold_d[i]  = end_evt ? sum[i] : hold_q[i];
        end

        ucnt_d = ucnt_q + 16'(end_evt);

        // Reads see the holding registers as they stand before this cycle's latch.
        dat_d = '0;
        if (bus.addr_i < UCNT_ADDR) begin
            dat_d = hold_q[bus.addr_i];
        end else if (bus.addr_i == UCNT_ADDR) begin
            dat_d = COUNT_BITS'(ucnt_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NCHAN; i++) begin
                count_q[i] <= '0;
                hold_q[i]  <= '0;
            end
            gate_q    <= '0;
            pps_dly_q <= 1'b0;
            dat_q     <= '0;
            update_q  <= 1'b0;
            ucnt_q    <= '0;
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                count_q[i] <= count_d[i];
                hold_q[i]  <= hold_d[i];
            end
            gate_q    <= gate_d;
            pps_dly_q <= bus.pps_i;
            dat_q     <= dat_d;
            update_q  <= end_evt;
            ucnt_q    <= ucnt_d;
        end
    end

    assign bus.dat_o          = dat_q;
    assign bus.update_o       = update_q;
    assign bus.update_count_o = ucnt_q;

endmodule

// File: tb/tb_radiant_trig_scaler.sv
// Self-checking bench for radiant_trig_scaler (NCHAN=24, COUNT_BITS=4, GATE_CYCLES=100).
module tb_radiant_trig_scaler;

    localparam int NCHAN = 24;
    localparam int CB    = 4;
    localparam int G     = 100;
    localparam int MAXC  = (1 << CB) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    radiant_trig_scaler_if #(.NCHAN(NCHAN), .COUNT_BITS(CB)) bus ();

    radiant_trig_scaler #(
        .NCHAN       (NCHAN),
        .COUNT_BITS  (CB),
        .GATE_CYCLES (G)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural reference: per-channel totals as plain integers.
    int m_cnt  [NCHAN];
    int m_hold [NCHAN];
    int m_gate, m_ucnt, m_dat, m_upd, m_ppsd;

    task automatic model_reset();
        for (int i = 0; i < NCHAN; i++) begin
            m_cnt[i]  = 0;
            m_hold[i] = 0;
        end
        m_gate = 0;
        m_ucnt = 0;
        m_dat  = 0;
        m_upd  = 0;
        m_ppsd = 0;
    endtask

    // One clock: drive inputs, advance the reference, return at posedge+1.
    task automatic step(input logic [NCHAN-1:0] s, input logic pe, input logic p,
                        input logic f, input logic [4:0] a);
        int  ev;
        int  nd;
        int  tot;
        bus.scal_i   = s;
        bus.pps_en_i = pe;
        bus.pps_i    = p;
        bus.force_i  = f;
        bus.addr_i   = a;
        ev = ((!pe && m_gate == G - 1) || (pe && p && m_ppsd == 0) || f) ? 1 : 0;
        if (int'(a) < NCHAN)       nd = m_hold[int'(a)];
        else if (int'(a) == NCHAN) nd = m_ucnt % (1 << CB);
        else                       nd = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < NCHAN; i++) begin
            tot = m_cnt[i] + int'(s[i]);
            if (tot > MAXC) tot = MAXC;
            if (ev != 0) begin
                m_hold[i] = tot;
                m_cnt[i]  = 0;
            end else begin
                m_cnt[i] = tot;
            end
        end
        m_gate = (ev != 0 || m_gate == G - 1) ? 0 : m_gate + 1;
        m_upd  = ev;
        m_ucnt = (m_ucnt + ev) % 65536;
        m_ppsd = int'(p);
        m_dat  = nd;
    endtask

    task automatic do_reset();
        bus.scal_i   = '0;
        bus.pps_en_i = 1'b0;
        bus.pps_i    = 1'b0;
        bus.force_i  = 1'b0;
        bus.addr_i   = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic pick(output logic [98:0] v, input int n);
        int k;
        int idx;
        v = '0;
        k = 0;
        while (k < n) begin
            idx = $urandom_range(0, 98);
            if (!v[idx]) begin
                v[idx] = 1'b1;
                k++;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (bus.dat_o !== '0) $display("FAIL reset_dat actual=%0d required=0", bus.dat_o);
        else n_pass++;
        n_total++;
        if (bus.update_o !== 1'b0) $display("FAIL reset_update actual=%0b required=0", bus.update_o);
        else n_pass++;
        n_total++;
        if (bus.update_count_o !== 16'd0) $display("FAIL reset_ucnt actual=%0d required=0", bus.update_count_o);
        else n_pass++;
        step('0, 1'b0, 1'b0, 1'b0, 5'(NCHAN));
        n_total++;
        if (bus.dat_o !== '0) $display("FAIL reset_read_ucnt actual=%0d required=0", bus.dat_o);
        else n_pass++;
    endtask

    task automatic test_basic_gate();
        logic [98:0]      p0, p5;
        logic [NCHAN-1:0] s;
        int               exp;
        int               found;
        do_reset();
        pick(p0, 7);
        pick(p5, 3);
        for (int c = 0; c < G; c++) begin
            s = '0;
            if (c < 99) begin
                s[0] = p0[c];
                s[5] = p5[c];
            end
            step(s, 1'b0, 1'b0, 1'b0, 5'd0);
            n_total++;
            if (bus.update_o !== (c == G - 1))
                $display("FAIL basic_update cycle=%0d actual=%0b required=%0b", c + 1, bus.update_o, c == G - 1);
            else n_pass++;
        end
        n_total++;
        if (bus.update_count_o !== 16'd1) $display("FAIL basic_ucnt actual=%0d required=1", bus.update_count_o);
        else n_pass++;
        for (int a = 0; a <= NCHAN; a++) begin
            step('0, 1'b0, 1'b0, 1'b0, 5'(a));
            exp = (a == 0) ? 7 : (a == 5) ? 3 : (a == NCHAN) ? 1 : 0;
            n_total++;
            if (bus.dat_o !== CB'(exp)) $display("FAIL basic_hold addr=%0d actual=%0d required=%0d", a, bus.dat_o, exp);
            else n_pass++;
        end
        found = -1;
        for (int k = 0; k < 200; k++) begin
            step('0, 1'b0, 1'b0, 1'b0, 5'd0);
            if (bus.update_o === 1'b1) begin
                found = k;
                break;
            end
        end
        n_total++;
        if (found != 74) $display("FAIL basic_second_gate_len actual=%0d required=74", found);
        else n_pass++;
        for (int a = 0; a < NCHAN; a++) begin
            step('0, 1'b0, 1'b0, 1'b0, 5'(a));
            n_total++;
            if (bus.dat_o !== '0) $display("FAIL basic_empty_gate addr=%0d actual=%0d required=0", a, bus.dat_o);
            else n_pass++;
        end
    endtask

    task automatic test_end_cycle_pulse();
        logic [NCHAN-1:0] s;
        do_reset();
        for (int c = 0; c < G; c++) begin
            s = '0;
            if (c == G - 1) s[1] = 1'b1;
            step(s, 1'b0, 1'b0, 1'b0, 5'd1);
        end
        n_total++;
        if (bus.update_o !== 1'b1) $display("FAIL endpulse_update actual=%0b required=1", bus.update_o);
        else n_pass++;
        step('0, 1'b0, 1'b0, 1'b0, 5'd1);
        n_total++;
        if (bus.dat_o !== CB'(1)) $display("FAIL endpulse_closing actual=%0d required=1", bus.dat_o);
        else n_pass++;
        for (int c = 0; c < G - 1; c++) step('0, 1'b0, 1'b0, 1'b0, 5'd1);
        n_total++;
        if (bus.update_o !== 1'b1) $display("FAIL endpulse_next_update actual=%0b required=1", bus.update_o);
        else n_pass++;
        step('0, 1'b0, 1'b0, 1'b0, 5'd1);
        n_total++;
        if (bus.dat_o !== '0) $display("FAIL endpulse_next_period actual=%0d required=0", bus.dat_o);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [98:0]      p2, p3;
        logic [NCHAN-1:0] s;
        do_reset();
        pick(p2, 20);
        pick(p3, 2);
        for (int c = 0; c < G; c++) begin
            s = '0;
            for (int i = 0; i < NCHAN; i++)
                if (i != 2 && i != 3) s[i] = ($urandom_range(0, 7) == 0);
            if (c < 99) begin
                s[2] = p2[c];
                s[3] = p3[c];
            end else begin
                s[2] = 1'b0;
                s[3] = 1'b0;
            end
            step(s, 1'b0, 1'b0, 1'b0, 5'd0);
        end
        step('0, 1'b0, 1'b0, 1'b0, 5'd2);
        n_total++;
        if (bus.dat_o !== CB'(15)) $display("FAIL sat_ch2 actual=%0d required=15", bus.dat_o);
        else n_pass++;
        step('0, 1'b0, 1'b0, 1'b0, 5'd3);
        n_total++;
        if (bus.dat_o !== CB'(2)) $display("FAIL sat_ch3 actual=%0d required=2", bus.dat_o);
        else n_pass++;
        for (int a = 0; a < NCHAN; a++) begin
            step('0, 1'b0, 1'b0, 1'b0, 5'(a));
            n_total++;
            if (bus.dat_o !== CB'(m_dat)) $display("FAIL sat_random addr=%0d actual=%0d required=%0d", a, bus.dat_o, m_dat);
            else n_pass++;
        end
    endtask

    task automatic test_pps_force();
        logic p;
        logic f;
        logic exp;
        int   nupd;
        do_reset();
        nupd = 0;
        for (int c = 0; c < 200; c++) begin
            p = (c >= 10) && (((c - 10) % 37) < 5) && (c < 10 + 37 * 5);
            f = (c == 10 + 37) || (c == 10 + 37 * 3) || (c == 199);
            step('0, 1'b1, p, f, 5'd0);
            exp = ((c >= 10) && ((c - 10) % 37 == 0) && (c < 10 + 37 * 5)) || (c == 199);
            n_total++;
            if (bus.update_o !== exp) $display("FAIL pps_update cycle=%0d actual=%0b required=%0b", c, bus.update_o, exp);
            else n_pass++;
            if (bus.update_o === 1'b1) nupd++;
        end
        n_total++;
        if (nupd != 6) $display("FAIL pps_update_total actual=%0d required=6", nupd);
        else n_pass++;
        n_total++;
        if (bus.update_count_o !== 16'd6) $display("FAIL pps_ucnt actual=%0d required=6", bus.update_count_o);
        else n_pass++;
    endtask

    task automatic test_readout();
        logic [NCHAN-1:0] s;
        do_reset();
        for (int c = 0; c < G - 1; c++) begin
            s = '0;
            s[5] = (c == 10) || (c == 20) || (c == 30);
            step(s, 1'b0, 1'b0, 1'b0, 5'd0);
        end
        step('0, 1'b0, 1'b0, 1'b0, 5'd5);
        n_total++;
        if (bus.dat_o !== '0) $display("FAIL read_end_cycle_old actual=%0d required=0", bus.dat_o);
        else n_pass++;
        step('0, 1'b0, 1'b0, 1'b0, 5'd5);
        n_total++;
        if (bus.dat_o !== CB'(3)) $display("FAIL read_addr5_new actual=%0d required=3", bus.dat_o);
        else n_pass++;
        step('0, 1'b0, 1'b0, 1'b0, 5'd24);
        n_total++;
        if (bus.dat_o !== CB'(1)) $display("FAIL read_addr24 actual=%0d required=1", bus.dat_o);
        else n_pass++;
        step('0, 1'b0, 1'b0, 1'b0, 5'd31);
        n_total++;
        if (bus.dat_o !== '0) $display("FAIL read_addr31 actual=%0d required=0", bus.dat_o);
        else n_pass++;
        step('0, 1'b0, 1'b0, 1'b0, 5'd25);
        n_total++;
        if (bus.dat_o !== '0) $display("FAIL read_addr25 actual=%0d required=0", bus.dat_o);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [NCHAN-1:0] s;
        logic [4:0]       a;
        do_reset();
        for (int k = 0; k < 17; k++) begin
            s = NCHAN'($urandom);
            a = 5'($urandom_range(0, 25));
            step(s, 1'b0, 1'b0, 1'b1, a);
            n_total++;
            if (bus.update_o !== 1'b1) $display("FAIL b2b_update k=%0d actual=%0b required=1", k, bus.update_o);
            else n_pass++;
            n_total++;
            if (bus.dat_o !== CB'(m_dat)) $display("FAIL b2b_dat k=%0d addr=%0d actual=%0d required=%0d", k, a, bus.dat_o, m_dat);
            else n_pass++;
        end
        n_total++;
        if (bus.update_count_o !== 16'd17) $display("FAIL b2b_ucnt actual=%0d required=17", bus.update_count_o);
        else n_pass++;
        step('0, 1'b0, 1'b0, 1'b0, 5'd24);
        n_total++;
        if (bus.update_o !== 1'b0) $display("FAIL b2b_update_stop actual=%0b required=0", bus.update_o);
        else n_pass++;
        n_total++;
        if (bus.dat_o !== CB'(1)) $display("FAIL b2b_ucnt_trunc actual=%0d required=1", bus.dat_o);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [NCHAN-1:0] s;
        do_reset();
        for (int c = 0; c < G; c++) begin
            s = '0;
            s[0] = (c < 5);
            step(s, 1'b0, 1'b0, 1'b0, 5'd0);
        end
        for (int c = 0; c < 24; c++) begin
            s = '0;
            s[0] = (c < 4);
            step(s, 1'b0, 1'b0, 1'b0, 5'd0);
        end
        n_total++;
        if (bus.dat_o !== CB'(5)) $display("FAIL areset_pre_dat actual=%0d required=5", bus.dat_o);
        else n_pass++;
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        n_total++;
        if (bus.dat_o !== '0) $display("FAIL areset_dat actual=%0d required=0", bus.dat_o);
        else n_pass++;
        n_total++;
        if (bus.update_count_o !== 16'd0) $display("FAIL areset_ucnt actual=%0d required=0", bus.update_count_o);
        else n_pass++;
        n_total++;
        if (bus.update_o !== 1'b0) $display("FAIL areset_update actual=%0b required=0", bus.update_o);
        else n_pass++;
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int c = 0; c < G; c++) begin
            s = '0;
            s[0] = (c == 5) || (c == 6);
            step(s, 1'b0, 1'b0, 1'b0, 5'd0);
            n_total++;
            if (bus.update_o !== (c == G - 1))
                $display("FAIL areset_gate_len cycle=%0d actual=%0b required=%0b", c + 1, bus.update_o, c == G - 1);
            else n_pass++;
        end
        step('0, 1'b0, 1'b0, 1'b0, 5'd0);
        n_total++;
        if (bus.dat_o !== CB'(2)) $display("FAIL areset_post_hold actual=%0d required=2", bus.dat_o);
        else n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_gate();
        test_end_cycle_pulse();
        test_saturation();
        test_pps_force();
        test_readout();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
